piso_serializer: RTL and testbench

//   Parallel-in/serial-out word serializer with a valid/ready load handshake.

---
 rtl/piso_serializer.sv | 94 +++++++++
 tb/tb_piso_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: word accepted on in_valid&&in_ready, first bit out the next cycle.
// Latency 1 clk to first bit, WIDTH clks per word; in_ready only on IDLE or the last bit, so back-to-back words stream gap-free.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             last_bit;
  logic             accept;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign in_ready = !rst && (state_q == IDLE || last_bit);
  assign accept   = in_valid && in_ready;

  // The shift register holds only the bits not yet driven; ser_out is loaded
  // directly from in_data on accept so the first bit appears one cycle later.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    ser_out_d     = 1'b0;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    if (accept) begin
      state_d       = SHIFT;
      cnt_d         = '0;
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      if (MSB_FIRST) begin
        ser_out_d = in_data[WIDTH-1];
        shreg_d   = in_data << 1;
      end else begin
        ser_out_d = in_data[0];
        shreg_d   = in_data >> 1;
      end
    end else if (state_q == SHIFT && !last_bit) begin
      cnt_d       = cnt_q + CW'(1);
      ser_valid_d = 1'b1;
      if (MSB_FIRST) begin
        ser_out_d = shreg_q[WIDTH-1];
        shreg_d   = shreg_q << 1;
      end else begin
        ser_out_d = shreg_q[0];
        shreg_d   = shreg_q >> 1;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a word/bit-index reference model.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;

  logic m_in_ready, m_ser_out, m_ser_valid, m_frame_start, m_busy;
  logic l_in_ready, l_ser_out, l_ser_valid, l_frame_start, l_busy;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .frame_start(m_frame_start), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .frame_start(l_frame_start), .busy(l_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passed = 0;

  // Reference model: the word in flight and the index of the bit currently shown.
  logic       mdl_active = 1'b0;
  logic [7:0] mdl_word   = 8'h00;
  int         mdl_k      = 0;

  // Per-cycle observations: {m out,valid,fs,busy, l out,valid,fs,busy, m rdy, l rdy}
  logic [9:0] obs_v, exp_v;
  logic [7:0] cap_m, cap_l;
  int         n_valid, n_fs;

  task automatic drive_cycle(input logic r, input logic v, input logic [7:0] d);
    logic       er;
    logic [1:0] obs_rdy;
    logic       em, el;
    rst = r; in_valid = v; in_data = d;
    #1;
    er      = !r && (!mdl_active || mdl_k == 7);
    obs_rdy = {m_in_ready, l_in_ready};
    @(posedge clk);
    if (r) begin
      mdl_active = 1'b0;
      mdl_k      = 0;
    end else if (v && er) begin
      mdl_active = 1'b1;
      mdl_word   = d;
      mdl_k      = 0;
    end else if (mdl_active && mdl_k != 7) begin
      mdl_k = mdl_k + 1;
    end else begin
      mdl_active = 1'b0;
    end
    @(negedge clk);
    em = mdl_active ? mdl_word[7 - mdl_k] : 1'b0;
    el = mdl_active ? mdl_word[mdl_k] : 1'b0;
    obs_v = {m_ser_out, m_ser_valid, m_frame_start, m_busy,
             l_ser_out, l_ser_valid, l_frame_start, l_busy, obs_rdy};
    exp_v = {em, mdl_active, mdl_active && mdl_k == 0, mdl_active,
             el, mdl_active, mdl_active && mdl_k == 0, mdl_active, er, er};
    if (m_ser_valid === 1'b1) begin
      cap_m   = {cap_m[6:0], m_ser_out};
      n_valid = n_valid + 1;
    end
    if (l_ser_valid === 1'b1) cap_l = {l_ser_out, cap_l[7:1]};
    if (m_frame_start === 1'b1) n_fs = n_fs + 1;
  endtask

  task automatic clear_capture();
    cap_m = 8'h00; cap_l = 8'h00; n_valid = 0; n_fs = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 8'($urandom));
      checks++;
      if (obs_v !== 10'b0) $display("FAIL reset_outputs cycle %0d: got %b want %b", i, obs_v, 10'b0);
      else passed++;
    end
    drive_cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if (obs_v !== exp_v) $display("FAIL reset_release: got %b want %b", obs_v, exp_v);
    else passed++;
  endtask

  task automatic test_bit_order();
    logic [7:0] rdy_seq;
    clear_capture();
    drive_cycle(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b0, 8'($urandom));
      checks++;
      if (obs_v !== exp_v) $display("FAIL msb_a5 cycle %0d: got %b want %b", i, obs_v, exp_v);
      else passed++;
    end
    checks++;
    if (cap_m !== 8'hA5 || n_valid != 8 || n_fs != 1)
      $display("FAIL msb_a5_word: got %h valid=%0d fs=%0d want a5 valid=8 fs=1", cap_m, n_valid, n_fs);
    else passed++;

    clear_capture();
    rdy_seq = 8'h00;
    drive_cycle(1'b0, 1'b1, 8'h01);
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(1'b0, 1'b0, 8'($urandom));
      if (i <= 8) rdy_seq = {rdy_seq[6:0], obs_v[0]};
      checks++;
      if (obs_v !== exp_v) $display("FAIL lsb_01 cycle %0d: got %b want %b", i, obs_v, exp_v);
      else passed++;
    end
    checks++;
    if (cap_l !== 8'h01 || rdy_seq !== 8'b0000_0001)
      $display("FAIL lsb_01_word: got %h ready=%b want 01 ready=00000001", cap_l, rdy_seq);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] fs_seq, vld_seq;
    clear_capture();
    fs_seq = '0; vld_seq = '0;
    for (int j = 0; j < 20; j++) begin
      if (j < 8)       drive_cycle(1'b0, 1'b1, 8'hFF);
      else if (j == 8) drive_cycle(1'b0, 1'b1, 8'h00);
      else             drive_cycle(1'b0, 1'b0, 8'($urandom));
      if (j < 16) begin
        fs_seq  = {fs_seq[14:0], m_frame_start};
        vld_seq = {vld_seq[14:0], m_ser_valid};
      end
      checks++;
      if (obs_v !== exp_v) $display("FAIL b2b cycle %0d: got %b want %b", j, obs_v, exp_v);
      else passed++;
    end
    checks++;
    if (vld_seq !== 16'hFFFF || fs_seq !== 16'h8080 || n_valid != 16)
      $display("FAIL b2b_stream: got valid=%h fs=%h n=%0d want valid=ffff fs=8080 n=16",
               vld_seq, fs_seq, n_valid);
    else passed++;
  endtask

  task automatic test_rst_abort();
    drive_cycle(1'b0, 1'b1, 8'hC3);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 8'hC3);
    drive_cycle(1'b1, 1'b0, 8'hC3);
    checks++;
    if (obs_v[9:2] !== 8'h00) $display("FAIL abort_outputs: got %b want 00000000", obs_v[9:2]);
    else passed++;
    clear_capture();
    drive_cycle(1'b0, 1'b1, 8'h3C);
    checks++;
    if (obs_v[1:0] !== 2'b11) $display("FAIL abort_ready: got %b want 11", obs_v[1:0]);
    else passed++;
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b0, 1'b0, 8'($urandom));
      checks++;
      if (obs_v !== exp_v) $display("FAIL abort_resend cycle %0d: got %b want %b", i, obs_v, exp_v);
      else passed++;
    end
    checks++;
    if (cap_m !== 8'h3C || cap_l !== 8'h3C || n_valid != 8)
      $display("FAIL abort_word: got m=%h l=%h n=%0d want 3c 3c 8", cap_m, cap_l, n_valid);
    else passed++;
  endtask

  task automatic test_data_change();
    clear_capture();
    drive_cycle(1'b0, 1'b1, 8'h81);
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b0, 1'b0, 8'h00);
      checks++;
      if (obs_v !== exp_v) $display("FAIL data_change cycle %0d: got %b want %b", i, obs_v, exp_v);
      else passed++;
    end
    checks++;
    if (cap_m !== 8'h81 || cap_l !== 8'h81)
      $display("FAIL data_change_word: got m=%h l=%h want 81 81", cap_m, cap_l);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
      checks++;
      if (obs_v !== exp_v) $display("FAIL random cycle %0d: got %b want %b", i, obs_v, exp_v);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    clear_capture();
    test_reset();
    test_bit_order();
    test_back_to_back();
    test_rst_abort();
    test_data_change();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
